vending_core_param: RTL
=======================

// Module: vending_core_param
// PURPOSE
//  Parametrised vending-machine core: N items with per-item price and stock count,
//  saturating credit from 5/10/50 coin pulses, single-cycle vend strobe, and timed
//  greedy change return (largest coin first, one coin per interval). Sits between
//  debounced/one-pulsed inputs plus keyboard select decode and the 7-seg/LED drivers.
// PARAMETERS
//  N_ITEMS      4                 number of selectable items (>=1)
//  CREDIT_W     8                 credit/price width, bits
//  MAX_CREDIT   100               credit saturation ceiling, multiple of 5, < 2**CREDIT_W
//  PRICE_VEC    {8'd20,8'd25,8'd30,8'd80} packed prices, item i at [i*CREDIT_W +: CREDIT_W], multiples of 5
//  STOCK_W      4                 per-item stock counter width
//  STOCK_INIT   3                 stock loaded per item at reset/restock
//  RETURN_TICKS 100_000_000       clk cycles between returned coins (>=1)
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          reset, synchronous, active-low
//  coin_5/10/50   in   1 each     one-cycle coin pulses
//  cancel         in   1          one-cycle pulse, request refund
//  sel_valid      in   1          one-cycle pulse, selection present
//  sel_idx        in   IW         item index, IW=max(1,$clog2(N_ITEMS))
//  restock        in   1          one-cycle pulse, reload all stock to STOCK_INIT
//  state          out  2          00 INSERT, 01 VEND, 10 RETURN
//  credit         out  CREDIT_W   current credit
//  avail          out  N_ITEMS    item i purchasable now
//  sold_out       out  N_ITEMS    stock[i]==0
//  vend_valid     out  1          one-cycle strobe, item dispensed
//  vend_idx       out  IW         item dispensed, valid with vend_valid
//  coin_out_valid out  1          one-cycle strobe, coin returned
//  coin_out_code  out  2          01=5, 10=10, 11=50; 00 when not valid
// BEHAVIOUR
//  Reset: state=INSERT, credit=0, all stock=STOCK_INIT, return counter=0,
//   vend_valid=0, vend_idx=0, coin_out_valid=0, coin_out_code=0; hence avail=0, sold_out=0.
//  avail[i] = (state==INSERT) && credit>=price[i] && stock[i]!=0; combinational from regs.
//  INSERT, per cycle, priority order:
//   1 cancel -> RETURN next cycle; coins and selection this cycle ignored.
//   2 accepted selection (sel_valid, sel_idx<N_ITEMS, credit>=price, stock!=0)
//     -> VEND next cycle, item index latched; a coin in the same cycle is still credited.
//   3 coin: only highest-priority coin counts (coin_5 > coin_10 > coin_50);
//     credit_next = min(credit+coin, MAX_CREDIT); excess discarded; compute in CREDIT_W+1 bits.
//   Rejected selection (bad idx, low credit, sold out): no state change.
//  VEND (exactly 1 cycle): credit -= price[latched]; stock[latched] -= 1;
//   vend_valid=1, vend_idx=latched registered for that cycle; -> RETURN. Coins/cancel/sel ignored.
//  RETURN: counter starts at 0 on entry; when counter==RETURN_TICKS-1 emit one coin:
//   largest of 50/10/5 <= credit, credit -= coin, coin_out_valid=1 one cycle, counter->0.
//   credit==0 (including on entry) -> INSERT next cycle, no coin. Residue 1..4 (not
//   reachable with legal params) -> cleared to 0 without coin. Inputs except restock ignored.
//  restock: accepted in any state; sets every stock to STOCK_INIT; wins over VEND decrement
//   in the same cycle.
//  rst_n low mid-VEND/RETURN: all state to reset values next edge; pending change is lost.
// TESTING
//  coin_10 x3, sel item2 (25) -> vend_valid,idx=2 one cycle; credit 5; one coin_out code 01; INSERT.
//  coin_50 x3 -> credit saturates 100; avail=4'b1111; cancel -> coins 50,50 every RETURN_TICKS.
//  credit 20, sel item0 (80) -> rejected, state stays INSERT, credit 20, no vend_valid.
//  buy item3 STOCK_INIT times -> sold_out[3]=1, avail[3]=0, further sel rejected; restock -> clears.
//  coin_5+coin_50 same cycle from 0 -> credit 5; sel+coin_10 same cycle at 30 (item1) -> credit 10 after VEND.
//  cancel at credit 0 -> RETURN one cycle, INSERT, no coin_out; rst_n low in RETURN -> credit 0, INSERT.

Source files
------------

// File: rtl/vending_core_param_if.sv
// Handshake bundle between the input decode front end and the vending core.
// Master drives coins/selection/control; slave (the core) drives status and strobes.
interface vending_core_param_if #(
   parameter int unsigned N_ITEMS  = 4,
   parameter int unsigned CREDIT_W = 8
);
   localparam int unsigned IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

   logic                coin_5;
   logic                coin_10;
   logic                coin_50;
   logic                cancel;
   logic                sel_valid;
   logic [IW-1:0]       sel_idx;
   logic                restock;
   logic [1:0]          state;
   logic [CREDIT_W-1:0] credit;
   logic [N_ITEMS-1:0]  avail;
   logic [N_ITEMS-1:0]  sold_out;
   logic                vend_valid;
   logic [IW-1:0]       vend_idx;
   logic                coin_out_valid;
   logic [1:0]          coin_out_code;

   modport master (
      output coin_5, coin_10, coin_50, cancel, sel_valid, sel_idx, restock,
      input  state, credit, avail, sold_out, vend_valid, vend_idx,
             coin_out_valid, coin_out_code
   );

   modport slave (
      input  coin_5, coin_10, coin_50, cancel, sel_valid, sel_idx, restock,
      output state, credit, avail, sold_out, vend_valid, vend_idx,
             coin_out_valid, coin_out_code
   );
endinterface

// File: rtl/vending_core_param.sv
// Vending core: saturating coin credit, per-item price/stock, one-cycle vend strobe
// and paced greedy change return (50/10/5, one coin per RETURN_TICKS cycles).
module vending_core_param #(
   parameter int unsigned                    N_ITEMS      = 4,
   parameter int unsigned                    CREDIT_W     = 8,
   parameter int unsigned                    MAX_CREDIT   = 100,
   parameter logic [N_ITEMS*CREDIT_W-1:0]    PRICE_VEC    = {8'd20, 8'd25, 8'd30, 8'd80},
   parameter int unsigned                    STOCK_W      = 4,
   parameter int unsigned                    STOCK_INIT   = 3,
   parameter int unsigned                    RETURN_TICKS = 100_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   vending_core_param_if.slave   bus
);
   localparam int unsigned IW    = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
   localparam int unsigned CNT_W = (RETURN_TICKS > 1) ? $clog2(RETURN_TICKS) : 1;

   localparam logic [1:0] ST_INSERT = 2'b00;
   localparam logic [1:0] ST_VEND   = 2'b01;
   localparam logic [1:0] ST_RETURN = 2'b10;

   localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(RETURN_TICKS - 1);
   localparam logic [CREDIT_W:0]   MAX_EXT   = (CREDIT_W + 1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] VAL_5     = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] VAL_10    = CREDIT_W'(10);
   localparam logic [CREDIT_W-1:0] VAL_50    = CREDIT_W'(50);
   localparam logic [STOCK_W-1:0]  STOCK_RLD = STOCK_W'(STOCK_INIT);

   logic [1:0]          state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic [STOCK_W-1:0]  stock_q [N_ITEMS];
   logic [CNT_W-1:0]    cnt_q;
   logic                vend_valid_q;
   logic [IW-1:0]       vend_idx_q;
   logic                coin_out_valid_q;
   logic [1:0]          coin_out_code_q;

   logic [CREDIT_W-1:0] price [N_ITEMS];
   logic [N_ITEMS-1:0]  avail_c;
   logic [N_ITEMS-1:0]  sold_out_c;

   always_comb begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
         price[i]      = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
         sold_out_c[i] = (stock_q[i] == '0);
         avail_c[i]    = (state_q == ST_INSERT) && (credit_q >= price[i]) && !sold_out_c[i];
      end
   end

   // Index lookups are done by match loops so an index >= N_ITEMS simply finds nothing.
   logic sel_hit;
   logic sel_ok;
   logic [CREDIT_W-1:0] vend_price;

   always_comb begin
      sel_hit    = 1'b0;
      sel_ok     = 1'b0;
      vend_price = '0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
         if (IW'(i) == bus.sel_idx) begin
            sel_hit = 1'b1;
            sel_ok  = avail_c[i];
         end
         if (IW'(i) == vend_idx_q) begin
            vend_price = price[i];
         end
      end
      sel_ok = sel_ok && sel_hit && bus.sel_valid;
   end

   logic                coin_any;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   credit_sum;
   logic [CREDIT_W-1:0] credit_sat;

   always_comb begin
      coin_any = bus.coin_5 | bus.coin_10 | bus.coin_50;
      if (bus.coin_5) begin
         coin_val = VAL_5;
      end else if (bus.coin_10) begin
         coin_val = VAL_10;
      end else if (bus.coin_50) begin
         coin_val = VAL_50;
      end else begin
         coin_val = '0;
      end
      credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
      credit_sat = (credit_sum > MAX_EXT) ? MAX_EXT[CREDIT_W-1:0] : credit_sum[CREDIT_W-1:0];
   end

   logic [CREDIT_W-1:0] ret_val;
   logic [1:0]          ret_code;

   always_comb begin
      if (credit_q >= VAL_50) begin
         ret_val  = VAL_50;
         ret_code = 2'b11;
      end else if (credit_q >= VAL_10) begin
         ret_val  = VAL_10;
         ret_code = 2'b10;
      end else if (credit_q >= VAL_5) begin
         ret_val  = VAL_5;
         ret_code = 2'b01;
      end else begin
         ret_val  = credit_q;
         ret_code = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= ST_INSERT;
         credit_q         <= '0;
         cnt_q            <= '0;
         vend_valid_q     <= 1'b0;
         vend_idx_q       <= '0;
         coin_out_valid_q <= 1'b0;
         coin_out_code_q  <= '0;
         for (int unsigned i = 0; i < N_ITEMS; i++) begin
            stock_q[i] <= STOCK_RLD;
         end
      end else begin
         vend_valid_q     <= 1'b0;
         coin_out_valid_q <= 1'b0;
         coin_out_code_q  <= '0;
         if (state_q != ST_RETURN) begin
            cnt_q <= '0;
         end

         case (state_q)
            ST_INSERT: begin
               if (bus.cancel) begin
                  state_q <= ST_RETURN;
               end else begin
                  if (sel_ok) begin
                     state_q      <= ST_VEND;
                     vend_valid_q <= 1'b1;
                     vend_idx_q   <= bus.sel_idx;
                  end
                  if (coin_any) begin
                     credit_q <= credit_sat;
                  end
               end
            end
            ST_VEND: begin
               credit_q <= credit_q - vend_price;
               state_q  <= ST_RETURN;
               for (int unsigned i = 0; i < N_ITEMS; i++) begin
                  if (IW'(i) == vend_idx_q) begin
                     stock_q[i] <= stock_q[i] - STOCK_W'(1);
                  end
               end
            end
            ST_RETURN: begin
               if (credit_q == '0) begin
                  state_q <= ST_INSERT;
               end else if (cnt_q == TICK_LAST) begin
                  // A sub-5 residue has ret_code 00: it is cleared without emitting a coin.
                  cnt_q            <= '0;
                  credit_q         <= credit_q - ret_val;
                  coin_out_valid_q <= (ret_code != 2'b00);
                  coin_out_code_q  <= ret_code;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_INSERT;
            end
         endcase

         // Placed after the FSM so a reload overrides a same-cycle vend decrement.
         if (bus.restock) begin
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
               stock_q[i] <= STOCK_RLD;
            end
         end
      end
   end

   assign bus.state          = state_q;
   assign bus.credit         = credit_q;
   assign bus.avail          = avail_c;
   assign bus.sold_out       = sold_out_c;
   assign bus.vend_valid     = vend_valid_q;
   assign bus.vend_idx       = vend_idx_q;
   assign bus.coin_out_valid = coin_out_valid_q;
   assign bus.coin_out_code  = coin_out_code_q;

endmodule
